sysram: RTL and testbench
=========================

SYSRAM -- requirements
Module: sysram

Interface
REQ-001 Parameter RAM_AW, default 11, SHALL set internal RAM address width (2^RAM_AW bytes).
REQ-002 Parameter NMI_VEC, default 16'h0000, SHALL set the reset value of the NMI vector register.
REQ-003 Parameter RESET_VEC, default 16'h0001, SHALL set the reset value of the RESET vector register.
REQ-004 Parameter IRQ_VEC, default 16'h0000, SHALL set the reset value of the IRQ/BRK vector register.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 n_reset  input  1  reset, asynchronous, active-low.
REQ-007 addr  input  16  CPU bus address, sampled every clk.
REQ-008 rw  input  1  1 = read, 0 = write, sampled with addr.
REQ-009 data_in  input  8  CPU write data, sampled when rw = 0.
REQ-010 data_out  output  8  registered read data.
REQ-011 data_oe  output  1  registered drive enable for the external tristate on data.

Function
REQ-012 Decode SHALL be: addr[15:13] = 0 -> RAM at index addr[RAM_AW-1:0] (mirrored); addr in 16'hFFFA..16'hFFFF -> vector bytes NMI lo/hi, RESET lo/hi, IRQ lo/hi; else unmapped.
REQ-013 Read (rw = 1) at edge N SHALL present the selected byte on data_out, with data_oe = 1, after edge N (1-cycle latency).
REQ-014 Write (rw = 0) at edge N SHALL update the target byte at edge N and SHALL set data_oe = 0 after edge N.
REQ-015 Writes to unmapped addresses SHALL be discarded with no state change except the open-bus latch.
REQ-016 Writes to 16'hFFFA..16'hFFFF SHALL update the corresponding vector register byte.
REQ-017 A read at edge N+1 of an address written at edge N SHALL return the newly written byte (write-first).
REQ-018 The open-bus latch SHALL load data_in on every write and the driven data_out value on every read.
REQ-019 Reads of mirrored addresses (e.g. 16'h0004, 16'h0804, 16'h1804) SHALL return the same byte.
REQ-020 data_out SHALL hold its last value while data_oe = 0.

Reset
REQ-021 While n_reset = 0: data_out = 8'h00, data_oe = 0, open-bus latch = 8'h00, vector registers = parameter values.
REQ-022 RAM contents SHALL NOT be reset.
REQ-023 A write sampled on the same edge that reset is asserted SHALL be discarded; the first access SHALL be sampled on the first rising clk after n_reset deasserts.

Configuration
REQ-024 With SYSRAM_OPENBUS_EN defined, unmapped reads SHALL return the open-bus latch value.
REQ-025 Without SYSRAM_OPENBUS_EN, unmapped reads SHALL return 8'h00 and the open-bus latch SHALL NOT be built.

Structure
REQ-026 Package sysram_pkg SHALL hold the region enum (REG_RAM, REG_VEC, REG_UNMAP), RAM_MIRROR_TOP = 16'h1FFF and VEC_BASE = 16'hFFFA.
REQ-027 The byte array SHALL be a sub-module sysram_mem (single-port synchronous RAM, write-first).

Verification
REQ-028 Reset release, read 16'hFFFC then 16'hFFFD -> data_out 8'h01 then 8'h00, data_oe = 1 each cycle after sampling.
REQ-029 Write 8'h34 to 16'h0004, read 16'h0804 and 16'h1804 -> 8'h34 both.
REQ-030 Write 8'hAB to 16'h0010 at edge N, read 16'h0010 at edge N+1 -> 8'hAB at edge N+2.
REQ-031 Write 8'h80 to 16'hFFFD, read 16'hFFFD -> 8'h80; assert n_reset, read again -> 8'h00.
REQ-032 Write 8'h5A to 16'h4000, read 16'h4000 -> 8'h5A with SYSRAM_OPENBUS_EN, 8'h00 without.
REQ-033 Assert n_reset on the edge of a write of 8'hFF to 16'h0020 after preloading 8'h11 -> read after release returns 8'h11.

Source files
------------

// File: rtl/sysram_pkg.sv
// System RAM shared definitions: address regions, decode constants and the
// address decoder used by the top level.
package sysram_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned VEC_N  = 6;

   localparam logic [ADDR_W-1:0] RAM_MIRROR_TOP = 16'h1FFF;
   localparam logic [ADDR_W-1:0] VEC_BASE       = 16'hFFFA;

   typedef enum logic [1:0] {
      REG_RAM   = 2'd0,
      REG_VEC   = 2'd1,
      REG_UNMAP = 2'd2
   } region_e;

   // Map a CPU address onto its region; RAM is mirrored through 0x0000..0x1FFF.
   function automatic region_e decode(input logic [ADDR_W-1:0] a);
      region_e r;
      if (a <= RAM_MIRROR_TOP)  r = REG_RAM;
      else if (a >= VEC_BASE)   r = REG_VEC;
      else                      r = REG_UNMAP;
      return r;
   endfunction

endpackage

// File: rtl/sysram_mem.sv
// Single-port synchronous byte RAM, write-first, no reset on contents.
// Ports: clk; we/re write/read enables; addr byte index; wdata write byte;
//        rdata registered read byte (holds when re = 0).
module sysram_mem
   import sysram_pkg::*;
#(
   parameter int unsigned AW = 11
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DATA_W-1:0] mem [DEPTH];

   // Array write and read register; a same-cycle read sees the new byte.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= we ? wdata : mem[addr];
      end
   end

endmodule

// File: rtl/sysram.sv
// System RAM block for an 8-bit CPU bus: mirrored internal RAM at
// 0x0000..0x1FFF, writable NMI/RESET/IRQ vector bytes at 0xFFFA..0xFFFF,
// everything else unmapped. One-cycle registered read latency.
// Optional feature macro: SYSRAM_OPENBUS_EN -- unmapped reads return the
// open-bus latch (last written byte or last driven read byte); without it
// unmapped reads return 8'h00 and no latch exists.
// Ports: clk; n_reset async active-low; addr/rw/data_in CPU bus (rw=1 read);
//        data_out read data (held while data_oe = 0); data_oe tristate enable.
module sysram
   import sysram_pkg::*;
#(
   parameter int unsigned RAM_AW    = 11,
   parameter logic [15:0] NMI_VEC   = 16'h0000,
   parameter logic [15:0] RESET_VEC = 16'h0001,
   parameter logic [15:0] IRQ_VEC   = 16'h0000
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rw,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe
);

   localparam logic [VEC_N*DATA_W-1:0] VEC_RST = {IRQ_VEC, RESET_VEC, NMI_VEC};

   region_e           region_c;
   logic [2:0]        vec_idx_c;
   logic              ram_we_c;
   logic              ram_re_c;
   logic              vec_we_c;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] unmap_c;

   logic              sel_ram_q, sel_ram_d;
   logic [DATA_W-1:0] other_q,   other_d;
   logic              oe_q;
   logic [DATA_W-1:0] vec_q [VEC_N];

   // Address decode and access strobes; RAM strobes are gated by reset so a
   // write coinciding with reset assertion never reaches the unreset array.
   always_comb begin
      region_c  = decode(addr);
      vec_idx_c = 3'(addr[2:0] - 3'd2);
      ram_we_c  = n_reset && !rw && (region_c == REG_RAM);
      ram_re_c  = n_reset &&  rw && (region_c == REG_RAM);
      vec_we_c  = !rw && (region_c == REG_VEC);
   end

`ifdef SYSRAM_OPENBUS_EN
   logic [DATA_W-1:0] ob_q;

   // After a read the latch equals the driven byte, so only writes need storage.
   always_comb begin
      unmap_c = oe_q ? data_out : ob_q;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         ob_q <= '0;
      end else if (!rw) begin
         ob_q <= data_in;
      end
   end
`else
   always_comb begin
      unmap_c = '0;
   end
`endif

   sysram_mem #(
      .AW (RAM_AW)
   ) u_mem (
      .clk   (clk),
      .we    (ram_we_c),
      .re    (ram_re_c),
      .addr  (addr[RAM_AW-1:0]),
      .wdata (data_in),
      .rdata (ram_rdata)
   );

   // Read-path source selection; writes leave it untouched so data_out holds.
   always_comb begin
      sel_ram_d = sel_ram_q;
      other_d   = other_q;
      if (rw) begin
         sel_ram_d = (region_c == REG_RAM);
         case (region_c)
            REG_VEC:   other_d = vec_q[vec_idx_c];
            REG_UNMAP: other_d = unmap_c;
            default:   other_d = other_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         sel_ram_q <= 1'b0;
         other_q   <= '0;
         oe_q      <= 1'b0;
      end else begin
         sel_ram_q <= sel_ram_d;
         other_q   <= other_d;
         oe_q      <= rw;
      end
   end

   // Vector bytes: NMI lo/hi, RESET lo/hi, IRQ lo/hi.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < VEC_N; i++) begin
            vec_q[i] <= VEC_RST[i*DATA_W +: DATA_W];
         end
      end else if (vec_we_c) begin
         vec_q[vec_idx_c] <= data_in;
      end
   end

   assign data_out = sel_ram_q ? ram_rdata : other_q;
   assign data_oe  = oe_q;

endmodule

// File: tb/tb_sysram.sv
module tb_sysram;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [15:0] addr;
   logic        rw;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        data_oe;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef SYSRAM_OPENBUS_EN
   localparam bit OPENBUS = 1'b1;
`else
   localparam bit OPENBUS = 1'b0;
`endif

   // Reference model state
   logic [7:0] ram_m [2048];
   logic [7:0] vec_m [6];
   logic [7:0] ob_m;
   logic [7:0] exp_out;
   logic       exp_oe;

   sysram dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .addr     (addr),
      .rw       (rw),
      .data_in  (data_in),
      .data_out (data_out),
      .data_oe  (data_oe)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      vec_m[0] = 8'h00; vec_m[1] = 8'h00;
      vec_m[2] = 8'h01; vec_m[3] = 8'h00;
      vec_m[4] = 8'h00; vec_m[5] = 8'h00;
      ob_m    = 8'h00;
      exp_out = 8'h00;
      exp_oe  = 1'b0;
   endtask

   task automatic model_access(input logic [15:0] a, input logic r, input logic [7:0] d);
      logic [7:0] v;
      int unsigned ai;
      ai = a;
      if (r) begin
         if (ai < 32'h2000)       v = ram_m[ai % 2048];
         else if (ai >= 32'hFFFA) v = vec_m[ai - 32'hFFFA];
         else                     v = OPENBUS ? ob_m : 8'h00;
         exp_out = v;
         exp_oe  = 1'b1;
         ob_m    = v;
      end else begin
         if (ai < 32'h2000)       ram_m[ai % 2048] = d;
         else if (ai >= 32'hFFFA) vec_m[ai - 32'hFFFA] = d;
         exp_oe = 1'b0;
         ob_m   = d;
      end
   endtask

   task automatic check(input string tag);
      n_checks++;
      assert (data_oe === exp_oe) else begin
         n_fail++;
         $error("FAIL %s data_oe observed=%b expected=%b", tag, data_oe, exp_oe);
      end
      n_checks++;
      assert (data_out === exp_out) else begin
         n_fail++;
         $error("FAIL %s data_out observed=%h expected=%h", tag, data_out, exp_out);
      end
   endtask

   // One bus cycle: drive, clock, update model, compare
   task automatic access(input logic [15:0] a, input logic r, input logic [7:0] d, input string tag);
      addr = a; rw = r; data_in = d;
      @(posedge clk);
      #1;
      model_access(a, r, d);
      check($sformatf("%s@%h", tag, a));
   endtask

   task automatic do_reset(input string tag);
      n_reset = 1'b0;
      rw = 1'b1; addr = 16'h4000; data_in = 8'h00;
      #1;
      model_reset();
      check(tag);
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_held"});
      n_reset = 1'b1;
   endtask

   initial begin
      logic [15:0] a;
      logic        r;
      logic [7:0]  d;
      int unsigned kind;

      n_reset = 1'b0; addr = 16'h0000; rw = 1'b1; data_in = 8'h00;
      model_reset();
      #2;
      check("reset_init");
      repeat (2) @(posedge clk);
      #1;
      n_reset = 1'b1;

      // Reset vector readback
      access(16'hFFFC, 1'b1, 8'h00, "rstvec_lo");
      access(16'hFFFD, 1'b1, 8'h00, "rstvec_hi");
      access(16'hFFFA, 1'b1, 8'h00, "nmivec_lo");
      access(16'hFFFF, 1'b1, 8'h00, "irqvec_hi");

      // Preload a window of RAM so every later RAM read hits known data
      for (int i = 0; i < 64; i++) begin
         access(16'(i), 1'b0, 8'($urandom), "preload");
      end

      // Mirrors
      access(16'h0004, 1'b0, 8'h34, "mir_wr");
      access(16'h0804, 1'b1, 8'h00, "mir_0804");
      access(16'h1804, 1'b1, 8'h00, "mir_1804");
      access(16'h0004, 1'b1, 8'h00, "mir_0004");

      // Write then immediate read
      access(16'h0010, 1'b0, 8'hAB, "wf_wr");
      access(16'h0010, 1'b1, 8'h00, "wf_rd");

      // Hold across writes
      access(16'h0011, 1'b0, 8'h77, "hold_wr1");
      access(16'hFFFE, 1'b0, 8'h99, "hold_wr2");
      access(16'hFFFE, 1'b1, 8'h00, "vec_irq_lo");

      // Vector write and reset restore
      access(16'hFFFD, 1'b0, 8'h80, "vec_wr");
      access(16'hFFFD, 1'b1, 8'h00, "vec_rd");
      do_reset("reset_mid");
      access(16'hFFFD, 1'b1, 8'h00, "vec_after_rst");
      access(16'hFFFE, 1'b1, 8'h00, "irq_after_rst");

      // Unmapped access and open bus
      access(16'h4000, 1'b0, 8'h5A, "ub_wr");
      access(16'h4000, 1'b1, 8'h00, "ub_rd");
      access(16'h2000, 1'b1, 8'h00, "ub_rd2");
      access(16'h0010, 1'b1, 8'h00, "ram_after_ub");
      access(16'hFFF9, 1'b1, 8'h00, "ub_edge");

      // Write coinciding with reset assertion is dropped
      access(16'h0020, 1'b0, 8'h11, "pre_0020");
      addr = 16'h0020; rw = 1'b0; data_in = 8'hFF; n_reset = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      check("rst_on_write");
      @(posedge clk);
      #1;
      n_reset = 1'b1;
      rw = 1'b1;
      access(16'h0020, 1'b1, 8'h00, "rst_write_dropped");

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 9);
         r    = 1'($urandom);
         d    = 8'($urandom);
         if (kind < 6) begin
            a = {3'b000, 2'($urandom), 5'd0, 6'($urandom_range(0, 63))};
         end else if (kind < 8) begin
            a = 16'hFFFA + 16'($urandom_range(0, 5));
         end else begin
            a = 16'($urandom_range(16'h2000, 16'hFFF9));
         end
         access(a, r, d, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
